// File: rtl/data_sink.sv
// data_sink: pixel stream consumer with FIFO, running statistics, programmable backpressure and CPU register access.
// Optional CRC-8 over accepted pixels when DATA_SINK_CRC_EN is defined (register 0x20).
module data_sink #(
    parameter int          DATA_W     = 8,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h0300_0000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              mem_valid,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic              irq
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic              en_q, mem_ready_q, irq_q;
    logic [7:0]        stall_q;
    logic [8:0]        thresh_q, level;
    logic [AW:0]       wptr_q, rptr_q, lvl;
    logic [31:0]       count_q, sum_q, mem_rdata_q, rdata;
    logic [DATA_W-1:0] min_q, max_q, head;
    logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
    logic [5:0]        word;
    logic              empty, full, req, wr, rd, clr, push, pop;
    logic              unused_ok;

    assign lvl       = wptr_q - rptr_q;
    assign level     = 9'(lvl);
    assign empty     = wptr_q == rptr_q;
    assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head      = fifo_q[rptr_q[AW-1:0]];
    assign in_ready  = en_q & ~full & ~stall_q[0];
    assign word      = mem_addr[7:2];
    assign req       = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]) && !mem_ready_q;
    assign wr        = req && (mem_wstrb != 4'h0);
    assign rd        = req && (mem_wstrb == 4'h0);
    assign clr       = wr && (word == 6'h00) && mem_wstrb[0] && mem_wdata[1];
    assign push      = in_valid && in_ready && !clr;
    assign pop       = rd && (word == 6'h03) && !empty;
    assign mem_ready = mem_ready_q;
    assign mem_rdata = mem_rdata_q;
    assign irq       = irq_q;
    assign unused_ok = ^{mem_wdata[31:9], mem_wstrb[3:2], mem_addr[1:0]};

`ifdef DATA_SINK_CRC_EN
    logic [7:0] crc_q, crc_d;
    always_comb begin
        crc_d = crc_q;
        for (int i = DATA_W - 1; i >= 0; i--)
            crc_d = {crc_d[6:0], 1'b0} ^ ((crc_d[7] ^ in_data[i]) ? 8'h07 : 8'h00);
    end
    always_ff @(posedge clk or negedge rstn)
        if (!rstn)    crc_q <= 8'h00;
        else if (clr) crc_q <= 8'h00;
        else if (push) crc_q <= crc_d;
`endif

    always_comb begin
        rdata = 32'h0;
        case (word)
            6'h00: rdata = {31'h0, en_q};
            6'h01: rdata = {24'h0, stall_q};
            6'h02: rdata = {15'h0, level, 6'h0, full, empty};
            6'h03: rdata = empty ? 32'h0 : (32'h8000_0000 | 32'(head));
            6'h04: rdata = count_q;
            6'h05: rdata = sum_q;
            6'h06: rdata = 32'({max_q, min_q});
            6'h07: rdata = {23'h0, thresh_q};
`ifdef DATA_SINK_CRC_EN
            6'h08: rdata = {24'h0, crc_q};
`endif
            default: rdata = 32'h0;
        endcase
    end

    // Storage array needs no reset: the pointers define what is valid.
    always_ff @(posedge clk)
        if (push) fifo_q[wptr_q[AW-1:0]] <= in_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            en_q        <= 1'b0;
            stall_q     <= 8'h00;
            thresh_q    <= 9'h000;
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= 32'h0;
            sum_q       <= 32'h0;
            min_q       <= '1;
            max_q       <= '0;
            mem_ready_q <= 1'b0;
            mem_rdata_q <= 32'h0;
            irq_q       <= 1'b0;
        end else begin
            mem_ready_q <= req;
            mem_rdata_q <= rd ? rdata : 32'h0;
            irq_q       <= (thresh_q != 9'h000) && (level >= thresh_q);
            if (en_q) stall_q <= {stall_q[0], stall_q[7:1]};
            if (wr && word == 6'h00 && mem_wstrb[0]) en_q <= mem_wdata[0];
            if (wr && word == 6'h01 && mem_wstrb[0]) stall_q <= mem_wdata[7:0];
            if (wr && word == 6'h07 && mem_wstrb[0]) thresh_q[7:0] <= mem_wdata[7:0];
            if (wr && word == 6'h07 && mem_wstrb[1]) thresh_q[8] <= mem_wdata[8];
            if (clr) begin
                wptr_q  <= '0;
                rptr_q  <= '0;
                count_q <= 32'h0;
                sum_q   <= 32'h0;
                min_q   <= '1;
                max_q   <= '0;
            end else begin
                if (push) begin
                    wptr_q  <= wptr_q + (AW + 1)'(1);
                    count_q <= count_q + 32'd1;
                    sum_q   <= sum_q + 32'(in_data);
                    if (in_data < min_q) min_q <= in_data;
                    if (in_data > max_q) max_q <= in_data;
                end
                if (pop) rptr_q <= rptr_q + (AW + 1)'(1);
            end
        end
    end
endmodule

// File: tb/tb_data_sink.sv
// tb_data_sink: directed self-checking bench for data_sink.
module tb_data_sink;
    localparam logic [31:0] B = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_wstrb = 4'h0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        irq;
    int          checks = 0;
    int          errors = 0;

    data_sink dut (
        .clk(clk), .rstn(rstn),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] q);
        logic got;
        got = 1'b0;
        q = 32'hx;
        mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_valid = 1'b1;
        for (int k = 0; k < 8 && !got; k++) begin
            @(posedge clk); #1;
            if (mem_ready) begin
                q = mem_rdata;
                got = 1'b1;
            end
        end
        mem_valid = 1'b0; mem_wstrb = 4'h0;
        chk("bus_ack", {31'h0, got}, 32'h1);
    endtask

    task automatic rd(input logic [7:0] off, input logic [31:0] exp, input string tag);
        logic [31:0] q;
        bus(B | 32'(off), 32'h0, 4'h0, q);
        chk(tag, q, exp);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] q;
        bus(B | 32'(off), d, 4'hF, q);
    endtask

    task automatic send(input logic [7:0] d);
        in_data = d; in_valid = 1'b1;
        for (int k = 0; k < 20 && !in_ready; k++) begin
            @(posedge clk); #1;
        end
        chk("send_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        int acc, tog;
        logic prev;
        logic [31:0] q;
        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_mem_ready", {31'h0, mem_ready}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        rd(8'h08, 32'h0000_0001, "rst_status");
        rd(8'h18, 32'h0000_00FF, "rst_minmax");
        rd(8'h10, 32'h0, "rst_count");
        chk("idle_rdata", mem_rdata, 32'h0);

        // basic stream
        wr(8'h00, 32'h1);
        wr(8'h04, 32'h0);
        send(8'h10); send(8'h20); send(8'h30);
        rd(8'h10, 32'd3, "count3");
        rd(8'h14, 32'h60, "sum3");
        rd(8'h18, 32'h3010, "minmax3");
        rd(8'h0C, 32'h8000_0010, "data0");
        rd(8'h0C, 32'h8000_0020, "data1");
        rd(8'h0C, 32'h8000_0030, "data2");
        rd(8'h0C, 32'h0, "data_empty");
        rd(8'h08, 32'h1, "status_empty");

        // fill to full
        in_data = 8'h05; in_valid = 1'b1; acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        chk("fill_accepted", 32'(acc), 32'd16);
        chk("full_in_ready", {31'h0, in_ready}, 32'h0);
        rd(8'h08, 32'h0000_1002, "status_full");
        rd(8'h0C, 32'h8000_0005, "data_full");
        acc = 0;
        for (int i = 0; i < 5; i++) begin
            if (in_ready) acc++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("refill_one", 32'(acc), 32'd1);
        rd(8'h10, 32'd20, "count20");
        rd(8'h14, 32'hB5, "sum20");
        wr(8'h00, 32'h3);
        rd(8'h08, 32'h1, "clr_status");

        // stall pattern
        wr(8'h04, 32'h55);
        in_valid = 1'b1; acc = 0; tog = 0; prev = in_ready;
        for (int i = 0; i < 16; i++) begin
            if (in_ready) acc++;
            if (i > 0 && in_ready != prev) tog++;
            prev = in_ready;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("stall_xfers", 32'(acc), 32'd8);
        chk("stall_toggles", 32'(tog), 32'd15);
        wr(8'h04, 32'h0);
        rd(8'h10, 32'd8, "stall_count");
        wr(8'h00, 32'h3);

        // threshold interrupt
        wr(8'h1C, 32'h4);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        chk("irq_lag", {31'h0, irq}, 32'h0);
        @(posedge clk); #1;
        chk("irq_rise", {31'h0, irq}, 32'h1);
        rd(8'h0C, 32'h8000_0011, "irq_pop");
        chk("irq_hold", {31'h0, irq}, 32'h1);
        @(posedge clk); #1;
        chk("irq_fall", {31'h0, irq}, 32'h0);

        // CLR coincident with a transfer
        in_data = 8'h99; in_valid = 1'b1;
        chk("clr_ready", {31'h0, in_ready}, 32'h1);
        bus(B, 32'h3, 4'h1, q);
        in_valid = 1'b0;
        rd(8'h10, 32'h0, "clr_count");
        rd(8'h14, 32'h0, "clr_sum");
        rd(8'h08, 32'h1, "clr_empty");
        rd(8'h18, 32'hFF, "clr_minmax");

        // EN=0 mid-stream
        send(8'h42);
        wr(8'h00, 32'h0);
        chk("dis_ready", {31'h0, in_ready}, 32'h0);
        wr(8'h04, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        rd(8'h04, 32'h1, "stall_frozen");
        rd(8'h0C, 32'h8000_0042, "dis_data");
        rd(8'h00, 32'h0, "ctrl_read");

        // unmapped, optional CRC, non-matching address
        rd(8'h24, 32'h0, "unmapped");
        wr(8'h04, 32'h0);
`ifdef DATA_SINK_CRC_EN
        wr(8'h00, 32'h3);
        send(8'h01);
        rd(8'h20, 32'h07, "crc");
`else
        rd(8'h20, 32'h0, "crc_off");
`endif
        mem_addr = 32'h0400_000C; mem_wstrb = 4'h0; mem_valid = 1'b1; acc = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (mem_ready) acc++;
        end
        mem_valid = 1'b0;
        chk("no_match", 32'(acc), 32'd0);

        // reset mid-operation
        wr(8'h00, 32'h1);
        send(8'h77); send(8'h78);
        #2 rstn = 1'b0;
        #1;
        chk("arst_ready", {31'h0, in_ready}, 32'h0);
        @(negedge clk); rstn = 1'b1;
        @(posedge clk); #1;
        rd(8'h08, 32'h1, "arst_status");
        rd(8'h10, 32'h0, "arst_count");
        rd(8'h18, 32'hFF, "arst_minmax");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
